// File: rtl/uart_rx_fifo_p.sv
// Oversampling UART receiver with start-bit validation, optional parity, stop check and receive FIFO.
// Outputs decode registered state; a push is visible one clk later and an overflowing push sets overrun.
module uart_rx_fifo_p #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Serial_In,
   input  logic [15:0]          baud_div,
   input  logic [15:0]          UCR,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] Parallel_Out,
   output logic [15:0]          USR
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_sync1, r_rx_s, r_rx_prev;
   logic [15:0]           r_baud_cnt;
   logic [TW-1:0]         r_tcnt;
   logic [BW-1:0]         r_bcnt;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_par_en, r_par_odd, r_par_bad;
   logic                  r_ovr, r_frm_err, r_par_err;
   logic [AW:0]           r_wptr, r_rptr;
   logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];

   logic w_rx_en, w_clr_err, w_tick, w_at_half, w_at_full, w_push;
   logic w_empty, w_full, w_pop, w_wr, w_ovr_set;
   logic w_unused_ucr;

   assign w_rx_en      = UCR[0];
   assign w_clr_err    = UCR[3];
   assign w_unused_ucr = ^UCR[15:4];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= Serial_In;
         r_rx_s    <= r_sync1;
         r_rx_prev <= r_rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_baud_cnt <= 16'd0;
      else if (!w_rx_en || r_baud_cnt == 16'd0)
         r_baud_cnt <= baud_div;
      else
         r_baud_cnt <= r_baud_cnt - 16'd1;
   end

   assign w_tick    = w_rx_en && (r_baud_cnt == 16'd0);
   assign w_at_half = w_tick && (r_tcnt == HALF_M1);
   assign w_at_full = w_tick && (r_tcnt == FULL_M1);

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      case (r_state)
         S_IDLE:   if (w_rx_en && r_rx_prev && !r_rx_s) w_state_nxt = S_START;
         S_START:  if (w_at_half) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
         S_DATA:   if (w_at_full && r_bcnt == LAST_BIT) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (w_at_full) w_state_nxt = S_STOP;
         S_STOP: begin
            if (w_at_full) begin
               w_state_nxt = S_IDLE;
               w_push      = 1'b1;
            end
         end
         default:  w_state_nxt = S_IDLE;
      endcase
      if (!w_rx_en) begin
         w_state_nxt = S_IDLE;
         w_push      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Tick count restarts on every state change so each phase measures from its own origin.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tcnt    <= '0;
         r_bcnt    <= '0;
         r_shift   <= '0;
         r_par_en  <= 1'b0;
         r_par_odd <= 1'b0;
         r_par_bad <= 1'b0;
      end else begin
         if (r_state != w_state_nxt || w_at_full) r_tcnt <= '0;
         else if (w_tick)                         r_tcnt <= r_tcnt + TW'(1);

         if (r_state != S_DATA) r_bcnt <= '0;
         else if (w_at_full)    r_bcnt <= r_bcnt + BW'(1);

         if (r_state == S_DATA && w_at_full)
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};

         if (r_state == S_IDLE && w_state_nxt == S_START) begin
            r_par_en  <= UCR[1];
            r_par_odd <= UCR[2];
            r_par_bad <= 1'b0;
         end else if (r_state == S_PARITY && w_at_full) begin
            r_par_bad <= (r_rx_s != (^r_shift ^ r_par_odd));
         end
      end
   end

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop     = rd_en && !w_empty;
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_ovr_set = w_push && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
         if (w_pop) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shift;
   end

   // A new error on the same clk as clr_err takes priority over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovr     <= 1'b0;
         r_frm_err <= 1'b0;
         r_par_err <= 1'b0;
      end else begin
         r_ovr     <= (r_ovr & ~w_clr_err) | w_ovr_set;
         r_frm_err <= (r_frm_err & ~w_clr_err) | (w_push & ~r_rx_s);
         r_par_err <= (r_par_err & ~w_clr_err) | (w_push & r_par_bad);
      end
   end

   assign Parallel_Out = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
   assign USR = {10'd0, (r_state != S_IDLE), w_full, r_par_err, r_frm_err, r_ovr, ~w_empty};

endmodule

// File: tb/tb_uart_rx_fifo_p.sv
// Bench for uart_rx_fifo_p: serial frames driven on the pin, results checked against a queue-based model.
module tb_uart_rx_fifo_p;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, Serial_In, rd_en;
   logic [15:0] baud_div, UCR, USR;
   logic [7:0]  Parallel_Out;

   int n_tests = 0;
   int n_fail  = 0;
   int bd      = 0;

   logic [7:0]  mq[$];
   bit          m_ovr, m_frm, m_par;
   logic [15:0] usr_trace [1024];

   always #5 clk = ~clk;

   uart_rx_fifo_p #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .Serial_In(Serial_In), .baud_div(baud_div),
      .UCR(UCR), .rd_en(rd_en), .Parallel_Out(Parallel_Out), .USR(USR)
   );

   function automatic logic [15:0] exp_usr();
      return {10'd0, 1'b0, (mq.size() == DEPTH), m_par, m_frm, m_ovr, (mq.size() != 0)};
   endfunction

   function automatic logic [7:0] exp_po();
      return (mq.size() != 0) ? mq[0] : 8'h00;
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_ovr = 0; m_frm = 0; m_par = 0;
   endfunction

   // One received frame as seen from outside: parity rule, stop rule, FIFO capacity.
   function automatic void model_frame(input logic [7:0] d, input bit pe, input bit odd,
                                       input bit pb, input bit sb, input bit pop_same);
      bit want;
      want = (($countones(d) % 2) == 1) ^ odd;
      if (pe && pb != want) m_par = 1;
      if (!sb) m_frm = 1;
      if (pop_same && mq.size() != 0) void'(mq.pop_front());
      if (mq.size() == DEPTH) m_ovr = 1;
      else mq.push_back(d);
   endfunction

   task automatic pop_one();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pe, input bit pb, input bit sb,
                             input int rd_at, input int rst_at);
      logic b;
      int   bt, nb, n;
      bit   ab;
      bt = 16 * (bd + 1);
      nb = pe ? 11 : 10;
      n  = 0;
      ab = 0;
      for (int k = 0; k < nb && !ab; k++) begin
         if (k == 0)            b = 1'b0;
         else if (k <= 8)       b = d[k-1];
         else if (pe && k == 9) b = pb;
         else                   b = sb;
         Serial_In = b;
         for (int j = 0; j < bt && !ab; j++) begin
            if (n == rd_at) rd_en = 1'b1;
            if (n == rst_at) begin
               rst = 1'b1;
               Serial_In = 1'b1;
            end
            if (n < 1024) usr_trace[n] = USR;
            @(negedge clk);
            rd_en = 1'b0;
            if (n == rst_at) begin
               rst = 1'b0;
               ab = 1;
            end
            n++;
         end
      end
      Serial_In = 1'b1;
      if (!ab) repeat (bt) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (USR !== 16'h0000) begin n_fail++; $display("FAIL reset_usr: got %h want 0000", USR); end
      n_tests++;
      if (Parallel_Out !== 8'h00) begin n_fail++; $display("FAIL reset_po: got %h want 00", Parallel_Out); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_basic();
      bd = 0; baud_div = 16'd0; UCR = 16'h0001;
      repeat (4) @(negedge clk);
      send_frame(8'hA5, 0, 0, 1, -1, -1);
      model_frame(8'hA5, 0, 0, 0, 1, 0);
      n_tests++;
      if (usr_trace[2] !== 16'h0000) begin n_fail++; $display("FAIL basic_idle_before_sync: got %h want 0000", usr_trace[2]); end
      n_tests++;
      if (usr_trace[3] !== 16'h0020) begin n_fail++; $display("FAIL basic_busy_after_edge: got %h want 0020", usr_trace[3]); end
      n_tests++;
      if (usr_trace[154] !== 16'h0020) begin n_fail++; $display("FAIL basic_before_push: got %h want 0020", usr_trace[154]); end
      n_tests++;
      if (usr_trace[155] !== 16'h0001) begin n_fail++; $display("FAIL basic_after_push: got %h want 0001", usr_trace[155]); end
      n_tests++;
      if (Parallel_Out !== 8'hA5) begin n_fail++; $display("FAIL basic_word: got %h want a5", Parallel_Out); end
      pop_one();
      n_tests++;
      if (USR !== 16'h0000 || Parallel_Out !== 8'h00)
         begin n_fail++; $display("FAIL basic_pop: got usr %h po %h want 0000/00", USR, Parallel_Out); end
   endtask

   task automatic test_parity();
      UCR = 16'h0003;
      send_frame(8'h3C, 1, 1, 1, -1, -1);
      model_frame(8'h3C, 1, 0, 1, 1, 0);
      n_tests++;
      if (USR !== 16'h0009 || Parallel_Out !== 8'h3C)
         begin n_fail++; $display("FAIL parity_bad: got usr %h po %h want 0009/3c", USR, Parallel_Out); end
      UCR = 16'h000B;
      @(negedge clk);
      UCR = 16'h0003;
      m_ovr = 0; m_frm = 0; m_par = 0;
      n_tests++;
      if (USR !== 16'h0001) begin n_fail++; $display("FAIL parity_clear: got %h want 0001", USR); end
      pop_one();
      UCR = 16'h0007;
      send_frame(8'h3C, 1, 1, 1, -1, -1);
      model_frame(8'h3C, 1, 1, 1, 1, 0);
      n_tests++;
      if (USR !== 16'h0001 || Parallel_Out !== 8'h3C)
         begin n_fail++; $display("FAIL parity_odd_good: got usr %h po %h want 0001/3c", USR, Parallel_Out); end
      pop_one();
      UCR = 16'h0001;
   endtask

   task automatic test_framing();
      send_frame(8'h55, 0, 0, 0, -1, -1);
      model_frame(8'h55, 0, 0, 0, 0, 0);
      n_tests++;
      if (USR !== 16'h0005 || Parallel_Out !== 8'h55)
         begin n_fail++; $display("FAIL framing_bad: got usr %h po %h want 0005/55", USR, Parallel_Out); end
      send_frame(8'h12, 0, 0, 1, -1, -1);
      model_frame(8'h12, 0, 0, 0, 1, 0);
      n_tests++;
      if (USR !== exp_usr()) begin n_fail++; $display("FAIL framing_next: got %h want %h", USR, exp_usr()); end
      while (mq.size() != 0) begin
         n_tests++;
         if (Parallel_Out !== mq[0]) begin n_fail++; $display("FAIL framing_drain: got %h want %h", Parallel_Out, mq[0]); end
         pop_one();
      end
      UCR = 16'h0009; @(negedge clk); UCR = 16'h0001;
      m_frm = 0;
   endtask

   task automatic test_overrun();
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 0, 0, 1, -1, -1);
         model_frame(8'(i), 0, 0, 0, 1, 0);
      end
      n_tests++;
      if (USR !== 16'h0013) begin n_fail++; $display("FAIL overrun_usr: got %h want 0013", USR); end
      for (int i = 1; i <= 4; i++) begin
         n_tests++;
         if (Parallel_Out !== 8'(i)) begin n_fail++; $display("FAIL overrun_drain: got %h want %h", Parallel_Out, 8'(i)); end
         pop_one();
      end
      UCR = 16'h0009; @(negedge clk); UCR = 16'h0001;
      m_ovr = 0;
      for (int i = 1; i <= 4; i++) begin
         send_frame(8'(i), 0, 0, 1, -1, -1);
         model_frame(8'(i), 0, 0, 0, 1, 0);
      end
      send_frame(8'h05, 0, 0, 1, 154, -1);
      model_frame(8'h05, 0, 0, 0, 1, 1);
      n_tests++;
      if (USR !== 16'h0011) begin n_fail++; $display("FAIL overrun_same_clk_usr: got %h want 0011", USR); end
      for (int i = 2; i <= 5; i++) begin
         n_tests++;
         if (Parallel_Out !== 8'(i)) begin n_fail++; $display("FAIL overrun_same_clk_drain: got %h want %h", Parallel_Out, 8'(i)); end
         pop_one();
      end
   endtask

   task automatic test_glitch_reset();
      Serial_In = 1'b0;
      repeat (3) @(negedge clk);
      Serial_In = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (USR !== 16'h0020) begin n_fail++; $display("FAIL glitch_start_seen: got %h want 0020", USR); end
      repeat (30) @(negedge clk);
      n_tests++;
      if (USR !== 16'h0000) begin n_fail++; $display("FAIL glitch_rejected: got %h want 0000", USR); end
      send_frame(8'h33, 0, 0, 1, -1, -1);
      model_frame(8'h33, 0, 0, 0, 1, 0);
      send_frame(8'hC3, 0, 0, 1, -1, 60);
      model_reset();
      n_tests++;
      if (USR !== 16'h0000 || Parallel_Out !== 8'h00)
         begin n_fail++; $display("FAIL midframe_reset: got usr %h po %h want 0000/00", USR, Parallel_Out); end
      repeat (20) @(negedge clk);
      send_frame(8'h7E, 0, 0, 1, -1, -1);
      model_frame(8'h7E, 0, 0, 0, 1, 0);
      n_tests++;
      if (USR !== 16'h0001 || Parallel_Out !== 8'h7E)
         begin n_fail++; $display("FAIL after_reset_frame: got usr %h po %h want 0001/7e", USR, Parallel_Out); end
      pop_one();
   endtask

   task automatic test_random();
      logic [7:0] d;
      bit pe, odd, pb, sb;
      for (int f = 0; f < 20; f++) begin
         bd = $urandom_range(0, 2);
         baud_div = 16'(bd);
         d   = 8'($urandom);
         pe  = $urandom_range(0, 1);
         odd = $urandom_range(0, 1);
         pb  = ((($countones(d) % 2) == 1) ^ odd) ^ ($urandom_range(0, 3) == 0);
         sb  = ($urandom_range(0, 4) != 0);
         UCR = {12'h000, 1'b0, odd, pe, 1'b1};
         repeat (20) @(negedge clk);
         send_frame(d, pe, pb, sb, -1, -1);
         model_frame(d, pe, odd, pb, sb, 0);
         n_tests++;
         if (USR !== exp_usr()) begin n_fail++; $display("FAIL random_usr frame %0d: got %h want %h", f, USR, exp_usr()); end
         n_tests++;
         if (Parallel_Out !== exp_po()) begin n_fail++; $display("FAIL random_po frame %0d: got %h want %h", f, Parallel_Out, exp_po()); end
         for (int p = $urandom_range(0, 2); p > 0; p--) pop_one();
         if ($urandom_range(0, 3) == 0) begin
            UCR[3] = 1'b1; @(negedge clk); UCR[3] = 1'b0;
            m_ovr = 0; m_frm = 0; m_par = 0;
         end
      end
      while (mq.size() != 0) begin
         n_tests++;
         if (Parallel_Out !== mq[0]) begin n_fail++; $display("FAIL random_drain: got %h want %h", Parallel_Out, mq[0]); end
         pop_one();
      end
   endtask

   initial begin
      rst = 1'b1; Serial_In = 1'b1; rd_en = 1'b0; UCR = 16'h0000; baud_div = 16'd0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_overrun();
      test_glitch_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo_p.md
Name: uart_rx_fifo_p

Overview:
- Parametrised serial-in/parallel-out UART receiver; successor to the fixed 8-bit shift-register receiver.
- Adds mid-bit oversampled sampling, start-bit validation, configurable word length, optional parity, stop-bit checking and a receive FIFO.
- Sits between the serial RX pin and the MCU bus.
- Controlled through the 16-bit UCR register; reports through the 16-bit USR register.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Serial_In  in  1  asynchronous RX line; idles high.
- baud_div  in  16  one sample tick every baud_div+1 clk cycles.
- UCR  in  16  control. [0] rx_en; [1] parity_en; [2] parity_odd; [3] clr_err, a level that clears sticky errors on every clk it is 1. Other bits are ignored.
- rd_en  in  1  pop the FIFO head; ignored when the FIFO is empty.
- Parallel_Out  out  DATA_BITS  FIFO head word; 0 when the FIFO is empty.
- USR  out  16  status. [0] data_ready (FIFO not empty); [1] overrun; [2] framing_err; [3] parity_err; [4] fifo_full; [5] busy (state != IDLE). Other bits read 0.

Behaviour:
- Reset: FSM goes to IDLE; the FIFO is emptied; sticky errors, tick and bit counters are cleared. Parallel_Out = 0; USR = 0x0000 on the cycle after rst is sampled high. rst wins over every other input, including mid-frame; any partial frame is discarded.
- Input synchroniser: Serial_In passes through a 2-flop synchroniser reset to 1. All decisions use the synchronised value rx_s, which lags the pin by 2 clk.
- Tick generator: 16-bit down-counter reloaded with baud_div; tick = 1 for one clk when the counter is 0. baud_div = 0 gives a tick every clk. The counter free-runs while rx_en = 1 and is held at reload while rx_en = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge of rx_s (previous 1, current 0) with rx_en = 1 moves to START and clears the tick count.
  - START: count ticks. At tick OVERSAMPLE/2 sample rx_s. If rx_s = 1 (false start), return to IDLE with no status change. If rx_s = 0, go to DATA with tick count cleared.
  - DATA: sample at every OVERSAMPLE-th tick, i.e. at mid-bit. Shift in LSB first. After DATA_BITS samples go to PARITY if parity_en = 1, otherwise to STOP.
  - PARITY: sample one bit. Expected value = XOR of data bits, inverted when parity_odd = 1. A mismatch marks the frame parity-bad.
  - STOP: sample one bit. A 0 marks the frame framing-bad. Then push the word and return to IDLE on the same clk as the sample; the next start edge can be detected immediately.
- UCR bits [1] and [2] are latched on entry to START. Changes during a frame do not affect it.
- rx_en falling mid-frame aborts to IDLE on the next clk. No push; FIFO and flags are kept.
- Push rules:
  - The word is pushed even if it is parity-bad or framing-bad; the matching sticky flag is set on the push clk.
  - If the FIFO is full and rd_en = 0 on the push clk, the word is discarded and overrun is set.
  - If the FIFO is full and rd_en = 1 on the same clk, the pop and push both occur and there is no overrun.
- Pop: rd_en with the FIFO non-empty advances the head. Parallel_Out and USR reflect the new state on the next clk (registered FIFO; 1-clk read latency after the pop).
- Sticky flags: USR[3:1] stay set until clr_err = 1 or reset. If clr_err and a new error occur on the same clk, the new error wins and the flag is set.
- Latency: push occurs (OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS + parity_en + 1)) ticks after the start edge on rx_s. USR[0] rises 1 clk after the push.
- Pointers are log2(FIFO_DEPTH)+1 bits wide: full and empty are distinguished by the MSB, and pointers wrap modulo 2*FIFO_DEPTH.

Test Plan:
- Defaults, baud_div = 0, UCR = 0x0001; send 8N1 0xA5 (16 clk per bit). Expect Parallel_Out = 0xA5 and USR = 0x0001 after the stop sample. rd_en pulse gives USR = 0x0000 and Parallel_Out = 0x00.
- UCR = 0x0003 (even parity); send 0x3C with parity bit 1 (wrong). Expect word 0x3C stored and USR = 0x0009. Hold UCR = 0x000B for one clk: USR = 0x0001.
- Send 0x55 with stop bit 0. Expect USR[2] = 1 and word 0x55 stored. Next good frame 0x12 is also received: FIFO holds 0x55, 0x12.
- FIFO_DEPTH = 4; send 0x01..0x05 with no reads. Expect USR = 0x0013, FIFO holds 0x01..0x04, 0x05 lost. Repeat with rd_en asserted on the 5th push clk: no overrun, FIFO holds 0x02..0x05.
- Low glitch of 3 clk on Serial_In while idle. Expect return to IDLE, USR = 0x0000, no push. Then assert rst at mid-data of a frame: USR = 0x0000 next clk, and a following frame 0x7E is received correctly.
